// File: rtl/p2_die_sprite_fetch.sv
// Die-sprite row fetcher: on each scanline's blanking, copies one sprite row from ROM into a
// line buffer, then serves opaque RGB565 pixels with one cycle of latency.
module p2_die_sprite_fetch #(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 8,
  parameter logic [15:0] TRANSPARENT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  vcount,
  input  logic [10:0] hcount,
  input  logic        sprite_en,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [6:0]  rom_address,
  output logic        rom_chipselect,
  input  logic [15:0] rom_readdata,
  output logic [15:0] pixel,
  output logic        pixel_valid,
  output logic        busy
);

  // Column counter runs 0..SPRITE_W: SPRITE_W issue cycles plus one trailing capture.
  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int IW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [9:0]    x_q, x_d;
  logic          row_valid_q, row_valid_d;
  logic [6:0]    rom_address_q, rom_address_d;
  logic          rom_cs_q, rom_cs_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [15:0]   line_buf_q [SPRITE_W];

  logic [10:0]   vdiff_s, hdiff_s;
  logic          hit_s, pix_hit_s, buf_we_s;
  logic [IW-1:0] buf_widx_s;
  logic [15:0]   buf_rd_s;

  // Row hit test: the 11-bit borrow rejects lines above the sprite, so there is no wrap.
  always_comb begin
    vdiff_s = {1'b0, vcount} - {1'b0, sprite_y};
    hit_s   = sprite_en && !vdiff_s[10] && (vdiff_s < 11'(SPRITE_H));
  end

  // Fetch sequencing; a line_start anywhere re-evaluates the row and restarts the fetch.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    x_d           = x_q;
    row_valid_d   = row_valid_q;
    rom_address_d = 7'd0;
    rom_cs_d      = 1'b0;
    buf_we_s      = 1'b0;
    buf_widx_s    = IW'(col_q - CW'(1));
    if (line_start) begin
      x_d         = sprite_x;
      row_valid_d = 1'b0;
      col_d       = CW'(0);
      if (hit_s) begin
        state_d       = FETCH;
        row_d         = vdiff_s[RW-1:0];
        rom_address_d = 7'(int'(vdiff_s[RW-1:0]) * SPRITE_W);
        rom_cs_d      = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH: begin
          buf_we_s = (col_q != CW'(0));
          if (col_q == CW'(SPRITE_W)) begin
            state_d     = IDLE;
            row_valid_d = 1'b1;
            col_d       = CW'(0);
          end else begin
            col_d = col_q + CW'(1);
            if (col_q < CW'(SPRITE_W - 1)) begin
              rom_address_d = 7'(int'(row_q) * SPRITE_W + int'(col_q) + 32'd1);
              rom_cs_d      = 1'b1;
            end else begin
              rom_cs_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Pixel lookup against the latched sprite column; hcount[10] is always off-screen.
  always_comb begin
    hdiff_s       = {1'b0, hcount[9:0]} - {1'b0, x_q};
    pix_hit_s     = row_valid_q && !hcount[10] && !hdiff_s[10] && (hdiff_s < 11'(SPRITE_W));
    buf_rd_s      = line_buf_q[hdiff_s[IW-1:0]];
    pixel_d       = 16'h0000;
    pixel_valid_d = 1'b0;
    if (pix_hit_s && (buf_rd_s != TRANSPARENT)) begin
      pixel_d       = buf_rd_s;
      pixel_valid_d = 1'b1;
    end else begin
      pixel_d       = 16'h0000;
      pixel_valid_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      col_q         <= CW'(0);
      row_q         <= RW'(0);
      x_q           <= 10'd0;
      row_valid_q   <= 1'b0;
      rom_address_q <= 7'd0;
      rom_cs_q      <= 1'b0;
      pixel_q       <= 16'h0000;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      x_q           <= x_d;
      row_valid_q   <= row_valid_d;
      rom_address_q <= rom_address_d;
      rom_cs_q      <= rom_cs_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  // Line buffer: the word for column c arrives one cycle after its address was issued.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      line_buf_q[buf_widx_s] <= rom_readdata;
    end
  end

  assign rom_address    = rom_address_q;
  assign rom_chipselect = rom_cs_q;
  assign pixel          = pixel_q;
  assign pixel_valid    = pixel_valid_q;
  assign busy           = (state_q == FETCH);

endmodule

// File: tb/tb_p2_die_sprite_fetch.sv
// Directed plus randomized bench for p2_die_sprite_fetch with a ROM model and a
// row-snapshot pixel reference model.
module tb_p2_die_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [9:0]  vcount, sprite_x, sprite_y;
  logic [10:0] hcount;
  logic        sprite_en;
  logic [6:0]  rom_address;
  logic        rom_chipselect;
  logic [15:0] rom_readdata;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] rom     [128];
  logic [15:0] exp_buf [16];
  bit          exp_valid;
  int          exp_x;

  p2_die_sprite_fetch dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .vcount(vcount),
    .hcount(hcount), .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect),
    .rom_readdata(rom_readdata), .pixel(pixel), .pixel_valid(pixel_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_readdata <= rom_chipselect ? rom[rom_address] : 16'hBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_px(input int h);
    int d;
    if (!exp_valid || h >= 1024) return 17'd0;
    d = h - exp_x;
    if (d < 0 || d >= 16) return 17'd0;
    if (exp_buf[d] == 16'h0000) return 17'd0;
    return {1'b1, exp_buf[d]};
  endfunction

  // Pulses line_start at the current negedge and checks ncyc following cycles.
  task automatic do_line(input int vc, input int sy, input int sx, input bit en, input int ncyc);
    int  d;
    bit  hit;
    d          = vc - sy;
    hit        = en && d >= 0 && d < 8;
    vcount     = 10'(vc);
    sprite_y   = 10'(sy);
    sprite_x   = 10'(sx);
    sprite_en  = en;
    hcount     = 11'(sx);
    line_start = 1'b1;
    exp_valid  = 1'b0;
    exp_x      = sx;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      line_start = 1'b0;
      if (hit) begin
        chk("busy", 32'(busy), (k < 17) ? 32'd1 : 32'd0);
        chk("rom_cs", 32'(rom_chipselect), (k < 16) ? 32'd1 : 32'd0);
        chk("rom_addr", 32'(rom_address), (k < 16) ? 32'(d * 16 + k) : 32'd0);
      end else begin
        chk("busy_miss", 32'(busy), 32'd0);
        chk("rom_cs_miss", 32'(rom_chipselect), 32'd0);
        chk("rom_addr_miss", 32'(rom_address), 32'd0);
      end
      if (k >= 1) chk("pv_during_fetch", 32'(pixel_valid), 32'd0);
    end
    if (hit && ncyc >= 18) begin
      exp_valid = 1'b1;
      for (int i = 0; i < 16; i++) exp_buf[i] = rom[d * 16 + i];
    end
  endtask

  task automatic pix(input int h);
    logic [16:0] e;
    hcount = 11'(h);
    @(negedge clk);
    e = model_px(h);
    chk("pixel_valid", 32'(pixel_valid), 32'(e[16]));
    chk("pixel", 32'(pixel), 32'(e[15:0]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(rom_address), 32'd0);
    chk({tag, "_cs"}, 32'(rom_chipselect), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pixel"}, 32'(pixel), 32'd0);
    chk({tag, "_pv"}, 32'(pixel_valid), 32'd0);
  endtask

  initial begin
    int sy, vc, sx, h;
    reset_n = 1'b0; line_start = 1'b0; vcount = 10'd0; hcount = 11'd0;
    sprite_en = 1'b0; sprite_x = 10'd0; sprite_y = 10'd0;
    exp_valid = 1'b0; exp_x = 0;
    for (int i = 0; i < 128; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
    rom[48] = 16'hF800;
    rom[49] = 16'h0000;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Row 3 of a sprite at y=100, then pixel lookups around x=200.
    do_line(103, 100, 200, 1'b1, 18);
    pix(200); pix(201); pix(216); pix(199);
    for (int i = 202; i < 216; i++) pix(i);
    pix(1024 + 200);
    // Buffer holds its row even when ROM contents change afterwards.
    rom[48] = 16'h1234;
    pix(200);

    // Misses: above, below, disabled.
    do_line(99, 100, 200, 1'b1, 4);
    for (int i = 198; i < 218; i += 3) pix(i);
    do_line(108, 100, 200, 1'b1, 4);
    pix(200); pix(205);
    do_line(103, 100, 200, 1'b0, 4);
    pix(200); pix(207);

    // No wrap from the bottom of the frame to the top.
    do_line(2, 1020, 1015, 1'b1, 4);
    pix(1023);
    do_line(1023, 1020, 1015, 1'b1, 18);
    pix(1023); pix(1015); pix(1022); pix(1024);

    // Abort mid-fetch and restart on row 1.
    do_line(103, 100, 200, 1'b1, 5);
    do_line(101, 100, 200, 1'b1, 18);
    for (int i = 198; i < 218; i++) pix(i);

    // Reset during a fetch.
    do_line(103, 100, 200, 1'b1, 8);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_valid = 1'b0;
    exp_x = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_reset_busy", 32'(busy), 32'd0);
      chk("post_reset_cs", 32'(rom_chipselect), 32'd0);
    end
    pix(0); pix(5); pix(200);

    // Randomized lines.
    for (int n = 0; n < 25; n++) begin
      sy = int'($urandom_range(0, 1023));
      vc = (sy + int'($urandom_range(0, 12)) - 2 + 1024) % 1024;
      sx = int'($urandom_range(0, 1023));
      do_line(vc, sy, sx, ($urandom_range(0, 5) != 0), 18);
      for (int i = 0; i < 4; i++) rom[$urandom_range(0, 127)] = 16'($urandom);
      for (int i = 0; i < 12; i++) begin
        h = sx + int'($urandom_range(0, 20)) - 2;
        if (h < 0) h = 0;
        pix(h);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/p2_die_sprite_fetch.md
P2_DIE_SPRITE_FETCH -- requirements
Module: p2_die_sprite_fetch

Interface
REQ-001 SHALL have parameter SPRITE_W, default 16, sprite width in pixels (words per row).
REQ-002 SHALL have parameter SPRITE_H, default 8, sprite height in rows; SPRITE_W*SPRITE_H = 128 ROM words.
REQ-003 SHALL have parameter TRANSPARENT, default 16'h0000, RGB565 key value treated as see-through.
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
REQ-005 SHALL have these remaining ports:
- line_start  in  1  single-cycle pulse at start of each scanline's blanking
- vcount  in  10  scanline about to be displayed
- hcount  in  11  current pixel column
- sprite_en  in  1  sprite visible
- sprite_x  in  10  sprite left column
- sprite_y  in  10  sprite top row
- rom_address  out  7  word address to die-sprite ROM
- rom_chipselect  out  1  ROM read strobe
- rom_readdata  in  16  ROM data, valid one cycle after rom_address
- pixel  out  16  RGB565 sprite pixel
- pixel_valid  out  1  pixel is opaque sprite pixel
- busy  out  1  row fetch in progress

Function
REQ-006 SHALL implement FSM states IDLE and FETCH.
REQ-007 On line_start, SHALL latch sprite_x, sprite_y, sprite_en; compute diff = {1'b0,vcount} - {1'b0,sprite_y} in 11 bits.
REQ-008 SHALL treat row as hit only if sprite_en=1, diff[10]=0 (no borrow), and diff < SPRITE_H; no wrap-around from row 1023 to 0.
REQ-009 On hit: go FETCH, row = diff, clear row_valid; on miss: stay/return IDLE, clear row_valid.
REQ-010 In FETCH SHALL issue addresses row*SPRITE_W + c for c = 0..SPRITE_W-1 on consecutive cycles with rom_chipselect=1.
REQ-011 SHALL capture rom_readdata into line buffer entry c one cycle after address c issued (read latency 1).
REQ-012 FETCH SHALL last SPRITE_W+1 cycles (16 issue, 1 trailing capture), then IDLE with row_valid=1.
REQ-013 rom_chipselect SHALL be 0 and rom_address hold 0 outside issue cycles.
REQ-014 busy SHALL equal 1 exactly while state = FETCH.
REQ-015 line_start during FETCH SHALL abort and restart per REQ-007..009 on the next cycle; partial buffer contents discarded (row_valid stays 0 until complete).
REQ-016 Pixel stage, every cycle: hdiff = {1'b0,hcount[9:0]} - {1'b0,latched sprite_x} (hcount[10]=1 means miss); if row_valid, no borrow, hdiff < SPRITE_W and buf[hdiff] != TRANSPARENT, register pixel=buf[hdiff], pixel_valid=1; else pixel=0, pixel_valid=0.
REQ-017 Pixel latency SHALL be exactly 1 cycle from hcount to pixel/pixel_valid.
REQ-018 Line buffer SHALL hold its contents until the next completed fetch; mid-fetch reads use row_valid=0 (no output).

Reset
REQ-019 While reset_n=0: state=IDLE, row_valid=0, busy=0, rom_chipselect=0, rom_address=0, pixel=0, pixel_valid=0, latched position = 0.
REQ-020 Reset assertion mid-FETCH SHALL abort immediately; after deassertion, no output until a new line_start completes a fetch.
REQ-021 Line buffer contents need not be reset.

Verification
REQ-022 sprite_y=100, vcount=103, line_start -> addresses 48..63 on 16 consecutive cycles, busy high 17 cycles, row_valid set.
REQ-023 After REQ-022, sprite_x=200, ROM word 48=16'hF800, 49=16'h0000 -> hcount=200 gives pixel=F800, valid=1 one cycle later; hcount=201 gives valid=0; hcount=216 gives valid=0.
REQ-024 sprite_y=100, vcount=99 or 108, or sprite_en=0 -> no fetch, busy=0, pixel_valid=0 all line.
REQ-025 sprite_y=1020, vcount=2 -> miss (no wrap); sprite_x=1015, hcount=1023 -> buf[8] shown.
REQ-026 line_start at fetch cycle 5 with vcount=101 -> restart at address 16..31, valid only after 17 further cycles.
REQ-027 reset_n low at fetch cycle 8 -> all outputs 0 asynchronously, stays IDLE after release.
